// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared register map and CTRL layout
// for the APB multi-channel timer.
package mtimer_pkg;

    typedef enum logic [1:0] {
        REG_LOAD  = 2'd0,
        REG_COUNT = 2'd1,
        REG_CTRL  = 2'd2,
        REG_CMP   = 2'd3
    } reg_e;

    localparam logic [7:0] STATUS_ADDR = 8'hF0;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PSC_LSB = 8;

    function automatic logic [3:0] addr_chan(
        input logic [7:0] addr
    );
        return addr[7:4];
    endfunction

    function automatic reg_e addr_reg(
        input logic [7:0] addr
    );
        return reg_e'(addr[3:2]);
    endfunction

endpackage

// File: rtl/mtimer_channel.sv
// mtimer_channel: one timer channel with its LOAD/CTRL/CMP
// registers, prescaler, counter and registered PWM compare.
module mtimer_channel
    import mtimer_pkg::*;
#(
    parameter int CW  = 32,
    parameter int PSW = 8
) (
    input  logic          pclk,
    input  logic          nreset,
    input  logic          load_we,
    input  logic          ctrl_we,
    input  logic          cmp_we,
    input  logic [31:0]   wdata,
    output logic [CW-1:0] load,
    output logic [CW-1:0] count,
    output logic [CW-1:0] cmp,
    output logic [31:0]   ctrl,
    output logic          irq_en,
    output logic          wrap,
    output logic          pwm
);

    logic           en;
    logic           oneshot;
    logic [PSW-1:0] psc;
    logic [PSW-1:0] presc;
    logic           tick;
    logic           unused_wdata;

    assign unused_wdata = ^wdata;

    assign tick = en && (presc == psc);
    // A LOAD write restarts the channel, so it also swallows a wrap.
    assign wrap = tick && !load_we && (count == load);

    // CTRL readback image; unimplemented bits read 0
    always_comb begin
        ctrl = '0;
        ctrl[CTRL_EN] = en;
        ctrl[CTRL_ONESHOT] = oneshot;
        ctrl[CTRL_IRQ_EN] = irq_en;
        ctrl[CTRL_PSC_LSB +: PSW] = psc;
    end

    // LOAD and CMP software registers
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            load <= '0;
            cmp  <= '0;
        end else begin
            if (load_we) load <= wdata[CW-1:0];
            if (cmp_we)  cmp  <= wdata[CW-1:0];
        end
    end

    // CTRL fields; software write beats the one-shot auto-disable
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
            psc     <= '0;
        end else if (ctrl_we) begin
            en      <= wdata[CTRL_EN];
            oneshot <= wdata[CTRL_ONESHOT];
            irq_en  <= wdata[CTRL_IRQ_EN];
            psc     <= wdata[CTRL_PSC_LSB +: PSW];
        end else if (wrap && oneshot) begin
            en <= 1'b0;
        end
    end

    // Prescaler and counter; LOAD write zeroes both
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
            presc <= '0;
        end else if (load_we) begin
            count <= '0;
            presc <= '0;
        end else if (en) begin
            if (tick) begin
                presc <= '0;
                count <= (count == load) ? '0 : count + CW'(1);
            end else begin
                presc <= presc + PSW'(1);
            end
        end
    end

    // Registered compare output, one cycle behind COUNT
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (count < cmp);
        end
    end

endmodule

// File: rtl/mtimer_apb.sv
// mtimer_apb: APB slave wrapping NCH timer channels,
// address decode, W1C STATUS and the combined IRQ.
module mtimer_apb
    import mtimer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int PSW = 8
) (
    input  logic           PCLK,
    input  logic           PRESETN,
    input  logic           PSEL,
    input  logic           PENABLE,
    input  logic           PWRITE,
    input  logic [7:0]     PADDR,
    input  logic [31:0]    PWDATA,
    output logic [31:0]    PRDATA,
    output logic           PREADY,
    output logic           PSLVERR,
    output logic           IRQ,
    output logic [NCH-1:0] PWM_OUT
);

    logic [3:0] chan;
    reg_e       rsel;
    logic       chan_hit;
    logic       status_hit;
    logic       addr_ok;
    logic       access;
    logic       wr_en;
    logic       unused_addr;

    logic [NCH-1:0]         load_we;
    logic [NCH-1:0]         ctrl_we;
    logic [NCH-1:0]         cmp_we;
    logic [NCH-1:0]         wrap;
    logic [NCH-1:0]         irq_en;
    logic [NCH-1:0]         status;
    logic [NCH-1:0]         w1c;
    logic [NCH-1:0][CW-1:0] load_q;
    logic [NCH-1:0][CW-1:0] count_q;
    logic [NCH-1:0][CW-1:0] cmp_q;
    logic [NCH-1:0][31:0]   ctrl_q;
    logic [31:0]            rdata;

    assign unused_addr = ^PADDR[1:0];

    assign chan       = addr_chan(PADDR);
    assign rsel       = addr_reg(PADDR);
    assign chan_hit   = chan < 4'(NCH);
    assign status_hit = PADDR == STATUS_ADDR;
    assign addr_ok    = chan_hit || status_hit;
    assign access     = PSEL && PENABLE;
    assign wr_en      = access && PWRITE && addr_ok;

    assign PREADY  = 1'b1;
    assign PSLVERR = PRESETN && access && !addr_ok;

    genvar n;
    generate
        for (n = 0; n < NCH; n++) begin : g_ch
            logic sel;

            assign sel = wr_en && chan_hit && (chan == 4'(n));
            assign load_we[n] = sel && (rsel == REG_LOAD);
            assign ctrl_we[n] = sel && (rsel == REG_CTRL);
            assign cmp_we[n]  = sel && (rsel == REG_CMP);

            mtimer_channel #(
                .CW (CW),
                .PSW(PSW)
            ) u_ch (
                .pclk   (PCLK),
                .nreset (PRESETN),
                .load_we(load_we[n]),
                .ctrl_we(ctrl_we[n]),
                .cmp_we (cmp_we[n]),
                .wdata  (PWDATA),
                .load   (load_q[n]),
                .count  (count_q[n]),
                .cmp    (cmp_q[n]),
                .ctrl   (ctrl_q[n]),
                .irq_en (irq_en[n]),
                .wrap   (wrap[n]),
                .pwm    (PWM_OUT[n])
            );
        end
    endgenerate

    assign w1c = (wr_en && status_hit) ? PWDATA[NCH-1:0] : '0;

    // STATUS: hardware set wins over a coincident W1C
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            status <= '0;
        end else begin
            status <= (status & ~w1c) | wrap;
        end
    end

    assign IRQ = |(status & irq_en);

    // Read mux of the addressed register; unmapped reads 0
    always_comb begin
        rdata = '0;
        if (status_hit) rdata[NCH-1:0] = status;
        for (int i = 0; i < NCH; i++) begin
            if (chan_hit && chan == 4'(i)) begin
                unique case (rsel)
                    REG_LOAD:  rdata[CW-1:0] = load_q[i];
                    REG_COUNT: rdata[CW-1:0] = count_q[i];
                    REG_CTRL:  rdata = ctrl_q[i];
                    REG_CMP:   rdata[CW-1:0] = cmp_q[i];
                endcase
            end
        end
    end

    assign PRDATA = (PRESETN && PSEL && !PWRITE) ? rdata : '0;

endmodule

// File: tb/tb_mtimer_apb.sv
// tb_mtimer_apb: table vectors, directed corner sequences
// and random APB traffic against a behavioural timer model.
module tb_mtimer_apb;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int PSW = 8;

    logic           PCLK    = 1'b0;
    logic           PRESETN = 1'b0;
    logic           PSEL    = 1'b0;
    logic           PENABLE = 1'b0;
    logic           PWRITE  = 1'b0;
    logic [7:0]     PADDR   = '0;
    logic [31:0]    PWDATA  = '0;
    logic [31:0]    PRDATA;
    logic           PREADY;
    logic           PSLVERR;
    logic           IRQ;
    logic [NCH-1:0] PWM_OUT;

    mtimer_apb #(
        .NCH(NCH),
        .CW (CW),
        .PSW(PSW)
    ) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .IRQ    (IRQ),
        .PWM_OUT(PWM_OUT)
    );

    always #5 PCLK = ~PCLK;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    longint         m_load [NCH];
    longint         m_cnt  [NCH];
    longint         m_cmp  [NCH];
    int             m_psc  [NCH];
    int             m_presc[NCH];
    bit             m_en   [NCH];
    bit             m_os   [NCH];
    bit             m_ie   [NCH];
    bit             m_pwm  [NCH];
    bit [NCH-1:0]   m_status;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    vec_t vt [18];
    int   seq24 [5] = '{0, 1, 2, 3, 0};
    int   seq25 [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic bit model_err(input logic [7:0] a);
        return !(a == 8'hF0 || int'(a[7:4]) < NCH);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int c;
        c = int'(a[7:4]);
        if (a == 8'hF0) return 32'(m_status);
        if (c >= NCH) return 32'h0;
        case (a[3:2])
            2'd0: return 32'(m_load[c]);
            2'd1: return 32'(m_cnt[c]);
            2'd2: return (32'(m_psc[c]) << 8) | (32'(m_ie[c]) << 2)
                         | (32'(m_os[c]) << 1) | 32'(m_en[c]);
            default: return 32'(m_cmp[c]);
        endcase
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_load[n] = 0; m_cnt[n] = 0; m_cmp[n] = 0;
            m_psc[n] = 0; m_presc[n] = 0;
            m_en[n] = 0; m_os[n] = 0; m_ie[n] = 0; m_pwm[n] = 0;
        end
        m_status = '0;
    endtask

    task automatic model_step();
        bit           wr;
        bit           hit;
        bit [NCH-1:0] wraps;
        int           c;
        int           r;
        wr = PSEL && PENABLE && PWRITE && !model_err(PADDR);
        c = int'(PADDR[7:4]);
        r = int'(PADDR[3:2]);
        wraps = '0;
        for (int n = 0; n < NCH; n++) begin
            hit = wr && (c == n);
            m_pwm[n] = m_en[n] && (m_cnt[n] < m_cmp[n]);
            if (hit && r == 0) begin
                m_cnt[n] = 0;
                m_presc[n] = 0;
            end else if (m_en[n]) begin
                if (m_presc[n] == m_psc[n]) begin
                    m_presc[n] = 0;
                    m_cnt[n] = (m_cnt[n] + 1) % (m_load[n] + 1);
                    wraps[n] = (m_cnt[n] == 0);
                end else begin
                    m_presc[n] = (m_presc[n] + 1) % (1 << PSW);
                end
            end
            if (hit && r == 0) m_load[n] = longint'(PWDATA);
            if (hit && r == 3) m_cmp[n] = longint'(PWDATA);
            if (hit && r == 2) begin
                m_en[n]  = PWDATA[0];
                m_os[n]  = PWDATA[1];
                m_ie[n]  = PWDATA[2];
                m_psc[n] = int'(PWDATA[8 +: PSW]);
            end else if (wraps[n] && m_os[n]) begin
                m_en[n] = 1'b0;
            end
        end
        if (wr && PADDR == 8'hF0) m_status = m_status & ~PWDATA[NCH-1:0];
        m_status = m_status | wraps;
    endtask

    always begin
        @(posedge PCLK or negedge PRESETN);
        if (!PRESETN) model_reset();
        else model_step();
    end

    always begin
        logic [NCH-1:0] pe;
        bit             ie;
        @(negedge PCLK);
        if (chk_on) begin
            ie = 1'b0;
            for (int n = 0; n < NCH; n++) begin
                pe[n] = m_pwm[n];
                if (m_status[n] && m_ie[n]) ie = 1'b1;
            end
            check("pwm_out", 32'(PWM_OUT), 32'(pe));
            check("irq", 32'(IRQ), 32'(ie));
            check("pready", 32'(PREADY), 32'h1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                             input bit exp_err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        check("pslverr_wr", 32'(PSLVERR), 32'(exp_err));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input bit use_model,
                            input logic [31:0] exp, input bit exp_err,
                            input string name);
        logic [31:0] e;
        bit          ee;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        e  = use_model ? model_read(a) : exp;
        ee = use_model ? model_err(a) : exp_err;
        check(name, PRDATA, e);
        check({name, "_err"}, 32'(PSLVERR), 32'(ee));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    endtask

    initial begin
        int          cnt;
        int          op;
        int          ch;
        logic [7:0]  a;
        logic [31:0] d;

        vt = '{
            '{1'b1, 8'h00, 32'h12345678, 32'h0,        1'b0},
            '{1'b0, 8'h00, 32'h0,        32'h12345678, 1'b0},
            '{1'b1, 8'h08, 32'hFFFFFFFE, 32'h0,        1'b0},
            '{1'b0, 8'h08, 32'h0,        32'h0000FF06, 1'b0},
            '{1'b1, 8'h0C, 32'hA5A5A5A5, 32'h0,        1'b0},
            '{1'b0, 8'h0C, 32'h0,        32'hA5A5A5A5, 1'b0},
            '{1'b1, 8'h04, 32'h0000DEAD, 32'h0,        1'b0},
            '{1'b0, 8'h04, 32'h0,        32'h0,        1'b0},
            '{1'b0, 8'h40, 32'h0,        32'h0,        1'b1},
            '{1'b1, 8'h44, 32'h00000055, 32'h0,        1'b1},
            '{1'b1, 8'h50, 32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b0, 8'h00, 32'h0,        32'h12345678, 1'b0},
            '{1'b0, 8'hF4, 32'h0,        32'h0,        1'b1},
            '{1'b1, 8'hF8, 32'h1,        32'h0,        1'b1},
            '{1'b0, 8'hF0, 32'h0,        32'h0,        1'b0},
            '{1'b1, 8'h3C, 32'h7,        32'h0,        1'b0},
            '{1'b0, 8'h3C, 32'h0,        32'h7,        1'b0},
            '{1'b0, 8'h38, 32'h0,        32'h0,        1'b0}
        };

        #2;
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_pwm", 32'(PWM_OUT), 32'h0);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        idle(2);
        PRESETN = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vt[i].wr) apb_write(vt[i].addr, vt[i].data, vt[i].err);
            else apb_read(vt[i].addr, 1'b0, vt[i].exp, vt[i].err, "vec_rd");
        end

        apb_write(8'h00, 32'd3, 1'b0);
        apb_write(8'h0C, 32'd0, 1'b0);
        apb_write(8'hF0, 32'hF, 1'b0);
        apb_write(8'h08, 32'h1, 1'b0);
        peek(8'h04);
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            check("r024_count", PRDATA, 32'(seq24[i]));
        end
        PADDR = 8'hF0;
        #1;
        check("r024_status", PRDATA, 32'h1);
        check("r024_irq_off", 32'(IRQ), 32'h0);
        @(posedge PCLK); #1;
        apb_write(8'h08, 32'h5, 1'b0);
        check("r024_irq_on", 32'(IRQ), 32'h1);
        apb_write(8'h08, 32'h0, 1'b0);

        apb_write(8'h10, 32'd1, 1'b0);
        apb_write(8'h18, 32'h203, 1'b0);
        peek(8'h14);
        for (int i = 0; i < 9; i++) begin
            @(negedge PCLK);
            check("r025_count", PRDATA, 32'(seq25[i]));
        end
        @(posedge PCLK); #1;
        apb_read(8'h18, 1'b0, 32'h202, 1'b0, "r025_ctrl");
        apb_read(8'hF0, 1'b0, 32'h3, 1'b0, "r025_status");

        apb_write(8'hF0, 32'hF, 1'b0);
        apb_write(8'h00, 32'd3, 1'b0);
        apb_write(8'h08, 32'h5, 1'b0);
        idle(2);
        apb_write(8'hF0, 32'h1, 1'b0);
        check("r027_irq", 32'(IRQ), 32'h1);
        apb_read(8'hF0, 1'b0, 32'h1, 1'b0, "r027_set_wins");
        apb_write(8'h08, 32'h0, 1'b0);
        apb_write(8'hF0, 32'h1, 1'b0);
        check("r027_irq_drop", 32'(IRQ), 32'h0);
        apb_read(8'hF0, 1'b0, 32'h0, 1'b0, "r027_cleared");

        apb_write(8'h20, 32'd9, 1'b0);
        apb_write(8'h2C, 32'd4, 1'b0);
        apb_write(8'h28, 32'h5, 1'b0);
        idle(3);
        cnt = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (PWM_OUT[2]) cnt++;
        end
        check("r026_duty4", 32'(cnt), 32'd8);
        @(posedge PCLK); #1;
        apb_write(8'h2C, 32'd0, 1'b0);
        idle(2);
        cnt = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (PWM_OUT[2]) cnt++;
        end
        check("r026_cmp0", 32'(cnt), 32'd0);
        @(posedge PCLK); #1;
        apb_write(8'h2C, 32'd12, 1'b0);
        idle(2);
        cnt = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (PWM_OUT[2]) cnt++;
        end
        check("r026_cmp12", 32'(cnt), 32'd20);
        @(posedge PCLK); #1;
        idle(12);
        check("r029_pre_irq", 32'(IRQ), 32'h1);

        #2;
        PRESETN = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h40;
        #1;
        check("r029_irq", 32'(IRQ), 32'h0);
        check("r029_pwm", 32'(PWM_OUT), 32'h0);
        check("r029_pslverr", 32'(PSLVERR), 32'h0);
        check("r029_prdata", PRDATA, 32'h0);
        #10;
        PRESETN = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        idle(4);
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(8'((c << 4) | (r << 2)), 1'b0, 32'h0, 1'b0,
                         "r029_reg");
            end
        end
        apb_read(8'hF0, 1'b0, 32'h0, 1'b0, "r029_status");

        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, NCH - 1);
            case (op)
                0: apb_write(8'(ch << 4), $urandom_range(0, 7), 1'b0);
                1, 2: begin
                    d = $urandom;
                    d[0] = ($urandom_range(0, 3) != 0);
                    d[15:8] = 8'($urandom_range(0, 3));
                    apb_write(8'((ch << 4) | 8), d, 1'b0);
                end
                3: apb_write(8'((ch << 4) | 12), $urandom_range(0, 9), 1'b0);
                4: apb_write(8'((ch << 4) | 4), $urandom, 1'b0);
                5: apb_write(8'hF0, 32'($urandom_range(0, 15)), 1'b0);
                6, 7: begin
                    a = 8'((ch << 4) | ($urandom_range(0, 3) << 2));
                    apb_read(a, 1'b1, 32'h0, 1'b0, "rnd_rd");
                end
                8: begin
                    a = 8'($urandom);
                    if ($urandom_range(0, 1) == 0)
                        apb_read(a, 1'b1, 32'h0, 1'b0, "rnd_any_rd");
                    else if (model_err(a))
                        apb_write(a, $urandom, 1'b1);
                    else
                        apb_read(a, 1'b1, 32'h0, 1'b0, "rnd_any_rd");
                end
                default: idle($urandom_range(1, 3));
            endcase
        end
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(8'((c << 4) | (r << 2)), 1'b1, 32'h0, 1'b0,
                         "final_rd");
            end
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
